csr_unit: RTL and testbench
===========================

CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_i  in  1  reset, synchronous, active-high.
REQ-003 csr_addr_i  in  12  CSR address (instruction bits 31:20).
REQ-004 wdata_i  in  32  operand: rs1 value or zero-extended zimm, already selected by datapath.
REQ-005 csr_write_i / csr_set_i / csr_clear_i  in  1 each  replace / OR / AND-NOT addressed CSR with wdata_i.
REQ-006 csr_interrupt_i  in  1  trap entry strobe, asserted by controller in FETCH2 when ipending_o=1.
REQ-007 csr_mret_i  in  1  trap return strobe.
REQ-008 pc_i  in  32  current PC, captured into mepc on trap entry.
REQ-009 ext_irq_i  in  1  asynchronous level external interrupt request.
REQ-010 rdata_o  out  32  combinational old value of addressed CSR (read-before-write).
REQ-011 ipending_o  out  1  enabled interrupt pending.
REQ-012 mtvec_o / mepc_o  out  32 each  trap target / return address for PC mux.

Function
REQ-013 Implemented CSRs: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344, mcycle 0xB00, mcycleh 0xB80, mtimecmp 0x7C0 (custom).
REQ-014 mstatus: MIE bit 3, MPIE bit 7 writable; MPP bits 12:11 read 2'b11; all other bits read 0, writes ignored.
REQ-015 mie: MTIE bit 7, MEIE bit 11 writable; other bits 0.
REQ-016 mip read-only: MEIP bit 11 = synchronized ext_irq_i; MTIP bit 7 = timer compare; writes ignored.
REQ-017 mtvec, mepc: bits 1:0 forced 0 on every write; direct mode only.
REQ-018 Unimplemented address: rdata_o=0, all writes ignored, no error signalled.
REQ-019 Write-op priority when several strobes high: write > set > clear; one update per cycle.
REQ-020 Set/clear with wdata_i=0 leaves register unchanged.
REQ-021 ext_irq_i passes a 2-flop synchronizer; MEIP follows ext_irq_i with 2-cycle latency.
REQ-022 mcycle/mcycleh: 64-bit counter, +1 every cycle, wraps 0xFFFF_FFFF_FFFF_FFFF -> 0; CSR write to either half wins over increment that cycle, other half holds.
REQ-023 MTIP = (mcycle[31:0] >= mtimecmp), unsigned; registered, 1-cycle latency.
REQ-024 ipending_o = MIE & ((MEIE & MEIP) | (MTIE & MTIP)); combinational from registers.
REQ-025 Trap entry (csr_interrupt_i): mepc<=pc_i[31:2],2'b00; MPIE<=MIE; MIE<=0; mcause<=0x8000_000B if external pending-enabled else 0x8000_0007 (external has priority).
REQ-026 mret (csr_mret_i): MIE<=MPIE; MPIE<=1; mepc, mcause unchanged.
REQ-027 csr_interrupt_i and csr_mret_i together: trap entry wins, mret ignored.
REQ-028 csr_interrupt_i with any write strobe same cycle: trap entry wins, CSR write dropped.
REQ-029 csr_mret_i with write to mstatus same cycle: mret update of MIE/MPIE wins; other CSR writes proceed.
REQ-030 ipending_o falls in the cycle after trap entry (MIE cleared), preventing re-entry.

Reset
REQ-031 On rst_i: mstatus MIE=0, MPIE=0; mie=0; mtvec=0; mepc=0; mcause=0; mscratch=0; mcycle=0; mtimecmp=0xFFFF_FFFF; synchronizer flops=0; MTIP=0.
REQ-032 Outputs after reset: ipending_o=0, mtvec_o=0, mepc_o=0; rdata_o per addressed register.
REQ-033 Reset mid-operation (any strobe high) overrides all updates that cycle.

Structure
REQ-034 Package csr_pkg holds CSR addresses, mstatus/mie/mip bit positions, mcause codes, mtimecmp reset value.
REQ-035 Sub-module csr_timer holds mcycle, mcycleh, mtimecmp, compare flop; csr_unit holds remaining CSRs, synchronizer, trap logic.

Verification
REQ-036 Reset, read 0x300 -> 0x0000_1800; 0x7C0 -> 0xFFFF_FFFF; ipending_o=0.
REQ-037 csrrw 0x305 wdata 0x0000_0103 -> mtvec_o=0x0000_0100; rdata_o in write cycle = 0.
REQ-038 mie=0x800, mstatus set 0x8, ext_irq_i=1 -> ipending_o=1 exactly 2 cycles after; csr_interrupt_i with pc_i=0x44 -> mepc=0x44, mcause=0x8000_000B, mstatus=0x1880, ipending_o=0 next cycle.
REQ-039 After REQ-038 drop ext_irq_i, pulse csr_mret_i -> mstatus=0x1888, mepc_o=0x44 held.
REQ-040 mtimecmp=20, mie=0x80, MIE=1, from mcycle=0 -> MTIP/ipending_o=1 one cycle after mcycle reaches 20; with ext and timer both pending, mcause=0x8000_000B.
REQ-041 csr_interrupt_i and csr_write_i to 0x340 same cycle -> mscratch unchanged; write to 0x344 or 0x123 -> no change, reads 0 for 0x123.

Source files
------------

// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the machine-mode CSR block.
// Holds CSR addresses, bit positions inside mstatus/mie/mip, trap cause
// codes, the mtimecmp reset value, the write-operation encoding and the
// helper that applies a write/set/clear operation to an old CSR value.
package csr_pkg;

    localparam int CSR_ADDR_W = 12;
    localparam int XLEN       = 32;

    // Implemented CSR addresses (0x7C0 is a custom timer compare register)
    localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS  = 12'h300;
    localparam logic [CSR_ADDR_W-1:0] CSR_MIE      = 12'h304;
    localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC    = 12'h305;
    localparam logic [CSR_ADDR_W-1:0] CSR_MSCRATCH = 12'h340;
    localparam logic [CSR_ADDR_W-1:0] CSR_MEPC     = 12'h341;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE   = 12'h342;
    localparam logic [CSR_ADDR_W-1:0] CSR_MIP      = 12'h344;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [CSR_ADDR_W-1:0] CSR_MTIMECMP = 12'h7C0;

    // mstatus fields
    localparam int         MSTATUS_MIE_BIT  = 3;
    localparam int         MSTATUS_MPIE_BIT = 7;
    localparam int         MSTATUS_MPP_LSB  = 11;
    localparam logic [1:0] MSTATUS_MPP_VAL  = 2'b11;

    // mie / mip fields share the same positions
    localparam int MIE_MTIE_BIT = 7;
    localparam int MIE_MEIE_BIT = 11;
    localparam int MIP_MTIP_BIT = 7;
    localparam int MIP_MEIP_BIT = 11;

    // Trap cause codes (interrupt bit set)
    localparam logic [XLEN-1:0] MCAUSE_EXT_IRQ   = 32'h8000_000B;
    localparam logic [XLEN-1:0] MCAUSE_TIMER_IRQ = 32'h8000_0007;

    localparam logic [XLEN-1:0] MTIMECMP_RESET = 32'hFFFF_FFFF;

    // Mask applied to mtvec/mepc so they are always word aligned
    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        CSR_OP_NONE,
        CSR_OP_WRITE,
        CSR_OP_SET,
        CSR_OP_CLEAR
    } csr_op_e;

    // Collapse the three strobes to one operation: write > set > clear
    function automatic csr_op_e csr_decode_op(input logic wr, input logic set,
                                              input logic clr);
        csr_op_e op;
        op = CSR_OP_NONE;
        if (wr) begin
            op = CSR_OP_WRITE;
        end else if (set) begin
            op = CSR_OP_SET;
        end else if (clr) begin
            op = CSR_OP_CLEAR;
        end
        return op;
    endfunction

    // New register value for a given operation; set/clear with zero
    // operand naturally return the old value
    function automatic logic [XLEN-1:0] csr_apply(input csr_op_e op,
                                                  input logic [XLEN-1:0] old_val,
                                                  input logic [XLEN-1:0] operand);
        logic [XLEN-1:0] res;
        res = old_val;
        case (op)
            CSR_OP_WRITE: res = operand;
            CSR_OP_SET:   res = old_val | operand;
            CSR_OP_CLEAR: res = old_val & ~operand;
            default:      res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_if.sv
// csr_if: bus between the core controller/datapath and the CSR unit.
// master: controller side (drives address, operand, strobes, PC).
// slave : CSR unit side (returns read data, pending flag, trap vectors).
//   csr_addr_i      CSR address from the instruction
//   wdata_i         operand (rs1 or zimm)
//   csr_write_i     replace addressed CSR
//   csr_set_i       OR operand into addressed CSR
//   csr_clear_i     AND-NOT operand into addressed CSR
//   csr_interrupt_i trap entry strobe
//   csr_mret_i      trap return strobe
//   pc_i            current PC
//   rdata_o         old value of the addressed CSR
//   ipending_o      enabled interrupt pending
//   mtvec_o/mepc_o  trap target / return address
interface csr_if;

    logic [csr_pkg::CSR_ADDR_W-1:0] csr_addr_i;
    logic [csr_pkg::XLEN-1:0]       wdata_i;
    logic                           csr_write_i;
    logic                           csr_set_i;
    logic                           csr_clear_i;
    logic                           csr_interrupt_i;
    logic                           csr_mret_i;
    logic [csr_pkg::XLEN-1:0]       pc_i;
    logic [csr_pkg::XLEN-1:0]       rdata_o;
    logic                           ipending_o;
    logic [csr_pkg::XLEN-1:0]       mtvec_o;
    logic [csr_pkg::XLEN-1:0]       mepc_o;

    modport master (
        output csr_addr_i, wdata_i, csr_write_i, csr_set_i, csr_clear_i,
        output csr_interrupt_i, csr_mret_i, pc_i,
        input  rdata_o, ipending_o, mtvec_o, mepc_o
    );

    modport slave (
        input  csr_addr_i, wdata_i, csr_write_i, csr_set_i, csr_clear_i,
        input  csr_interrupt_i, csr_mret_i, pc_i,
        output rdata_o, ipending_o, mtvec_o, mepc_o
    );

endinterface

// File: rtl/csr_timer.sv
// csr_timer: 64-bit cycle counter (mcycle/mcycleh), the mtimecmp compare
// register and the registered timer-interrupt flag (MTIP).
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   mcycle_we_i       load low counter half with wval_i
//   mcycleh_we_i      load high counter half with wval_i
//   mtimecmp_we_i     load mtimecmp with wval_i
//   wval_i            already-resolved new CSR value
//   mcycle_o/mcycleh_o/mtimecmp_o  current register values
//   mtip_o            registered (mcycle[31:0] >= mtimecmp)
module csr_timer
    import csr_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            mcycle_we_i,
    input  logic            mcycleh_we_i,
    input  logic            mtimecmp_we_i,
    input  logic [XLEN-1:0] wval_i,
    output logic [XLEN-1:0] mcycle_o,
    output logic [XLEN-1:0] mcycleh_o,
    output logic [XLEN-1:0] mtimecmp_o,
    output logic            mtip_o
);

    logic [63:0]     cycle_q,    cycle_d;
    logic [XLEN-1:0] mtimecmp_q, mtimecmp_d;
    logic            mtip_q,     mtip_d;

    // A write to one counter half replaces the increment for that cycle
    // and freezes the other half; otherwise the full 64 bits count up
    // and wrap naturally.
    always_comb begin
        cycle_d    = cycle_q + 64'd1;
        mtimecmp_d = mtimecmp_q;
        if (mcycle_we_i) begin
            cycle_d = {cycle_q[63:32], wval_i};
        end else if (mcycleh_we_i) begin
            cycle_d = {wval_i, cycle_q[31:0]};
        end
        if (mtimecmp_we_i) begin
            mtimecmp_d = wval_i;
        end
        // Compare on current register values; result is seen next cycle
        mtip_d = (cycle_q[31:0] >= mtimecmp_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_q    <= 64'd0;
            mtimecmp_q <= MTIMECMP_RESET;
            mtip_q     <= 1'b0;
        end else begin
            cycle_q    <= cycle_d;
            mtimecmp_q <= mtimecmp_d;
            mtip_q     <= mtip_d;
        end
    end

    assign mcycle_o   = cycle_q[31:0];
    assign mcycleh_o  = cycle_q[63:32];
    assign mtimecmp_o = mtimecmp_q;
    assign mtip_o     = mtip_q;

endmodule

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with trap entry/return handling.
// Holds mstatus (MIE/MPIE), mie (MTIE/MEIE), mtvec, mscratch, mepc, mcause,
// the external-interrupt synchronizer and the trap logic; the cycle
// counter and timer compare live in csr_timer.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   ext_irq_i  asynchronous level external interrupt request
//   bus        csr_if slave: address/operand/strobes in, read data,
//              pending flag, mtvec and mepc out
module csr_unit
    import csr_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic ext_irq_i,
    csr_if.slave bus
);

    logic            mstat_mie_q,  mstat_mie_d;
    logic            mstat_mpie_q, mstat_mpie_d;
    logic            mie_mtie_q,   mie_mtie_d;
    logic            mie_meie_q,   mie_meie_d;
    logic [XLEN-1:0] mtvec_q,      mtvec_d;
    logic [XLEN-1:0] mscratch_q,   mscratch_d;
    logic [XLEN-1:0] mepc_q,       mepc_d;
    logic [XLEN-1:0] mcause_q,     mcause_d;
    logic            irq_sync1_q,  irq_sync1_d;
    logic            irq_sync2_q,  irq_sync2_d;

    logic [XLEN-1:0] mcycle, mcycleh, mtimecmp;
    logic            mtip;
    logic            meip;

    logic [XLEN-1:0] mstatus_rd, mie_rd, mip_rd;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] wval;
    csr_op_e         op;
    logic            op_en;
    logic            we_mstatus, we_mie, we_mtvec, we_mscratch;
    logic            we_mepc, we_mcause, we_mcycle, we_mcycleh, we_mtimecmp;

    assign meip = irq_sync2_q;

    // Assemble the packed views of the sparse registers; unimplemented
    // bits read as zero and MPP is hardwired to machine mode.
    always_comb begin
        mstatus_rd = '0;
        mstatus_rd[MSTATUS_MIE_BIT]                    = mstat_mie_q;
        mstatus_rd[MSTATUS_MPIE_BIT]                   = mstat_mpie_q;
        mstatus_rd[MSTATUS_MPP_LSB+1:MSTATUS_MPP_LSB]  = MSTATUS_MPP_VAL;
        mie_rd = '0;
        mie_rd[MIE_MTIE_BIT] = mie_mtie_q;
        mie_rd[MIE_MEIE_BIT] = mie_meie_q;
        mip_rd = '0;
        mip_rd[MIP_MTIP_BIT] = mtip;
        mip_rd[MIP_MEIP_BIT] = meip;
    end

    // Read mux: old value of the addressed CSR, zero for unknown addresses
    always_comb begin
        rdata = '0;
        case (bus.csr_addr_i)
            CSR_MSTATUS:  rdata = mstatus_rd;
            CSR_MIE:      rdata = mie_rd;
            CSR_MTVEC:    rdata = mtvec_q;
            CSR_MSCRATCH: rdata = mscratch_q;
            CSR_MEPC:     rdata = mepc_q;
            CSR_MCAUSE:   rdata = mcause_q;
            CSR_MIP:      rdata = mip_rd;
            CSR_MCYCLE:   rdata = mcycle;
            CSR_MCYCLEH:  rdata = mcycleh;
            CSR_MTIMECMP: rdata = mtimecmp;
            default:      rdata = '0;
        endcase
    end

    // Resolve the software write: one operation per cycle, and a trap
    // entry in the same cycle drops the write entirely. mip and unknown
    // addresses have no write enable, so writes to them vanish.
    always_comb begin
        op    = csr_decode_op(bus.csr_write_i, bus.csr_set_i, bus.csr_clear_i);
        op_en = (op != CSR_OP_NONE) && !bus.csr_interrupt_i;
        wval  = csr_apply(op, rdata, bus.wdata_i);
        we_mstatus  = op_en && (bus.csr_addr_i == CSR_MSTATUS);
        we_mie      = op_en && (bus.csr_addr_i == CSR_MIE);
        we_mtvec    = op_en && (bus.csr_addr_i == CSR_MTVEC);
        we_mscratch = op_en && (bus.csr_addr_i == CSR_MSCRATCH);
        we_mepc     = op_en && (bus.csr_addr_i == CSR_MEPC);
        we_mcause   = op_en && (bus.csr_addr_i == CSR_MCAUSE);
        we_mcycle   = op_en && (bus.csr_addr_i == CSR_MCYCLE);
        we_mcycleh  = op_en && (bus.csr_addr_i == CSR_MCYCLEH);
        we_mtimecmp = op_en && (bus.csr_addr_i == CSR_MTIMECMP);
    end

    // Next-state for the CSRs. Order of the if-chain sets priority:
    // software write first, then mret overrides MIE/MPIE, then trap entry
    // overrides mret and owns mepc/mcause.
    always_comb begin
        mstat_mie_d  = mstat_mie_q;
        mstat_mpie_d = mstat_mpie_q;
        mie_mtie_d   = mie_mtie_q;
        mie_meie_d   = mie_meie_q;
        mtvec_d      = mtvec_q;
        mscratch_d   = mscratch_q;
        mepc_d       = mepc_q;
        mcause_d     = mcause_q;
        irq_sync1_d  = ext_irq_i;
        irq_sync2_d  = irq_sync1_q;

        if (we_mstatus) begin
            mstat_mie_d  = wval[MSTATUS_MIE_BIT];
            mstat_mpie_d = wval[MSTATUS_MPIE_BIT];
        end
        if (we_mie) begin
            mie_mtie_d = wval[MIE_MTIE_BIT];
            mie_meie_d = wval[MIE_MEIE_BIT];
        end
        if (we_mtvec) begin
            mtvec_d = wval & ALIGN_MASK;
        end
        if (we_mscratch) begin
            mscratch_d = wval;
        end
        if (we_mepc) begin
            mepc_d = wval & ALIGN_MASK;
        end
        if (we_mcause) begin
            mcause_d = wval;
        end

        if (bus.csr_interrupt_i) begin
            mepc_d       = bus.pc_i & ALIGN_MASK;
            mstat_mpie_d = mstat_mie_q;
            mstat_mie_d  = 1'b0;
            mcause_d     = (mie_meie_q && meip) ? MCAUSE_EXT_IRQ : MCAUSE_TIMER_IRQ;
        end else if (bus.csr_mret_i) begin
            mstat_mie_d  = mstat_mpie_q;
            mstat_mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mstat_mie_q  <= 1'b0;
            mstat_mpie_q <= 1'b0;
            mie_mtie_q   <= 1'b0;
            mie_meie_q   <= 1'b0;
            mtvec_q      <= '0;
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            irq_sync1_q  <= 1'b0;
            irq_sync2_q  <= 1'b0;
        end else begin
            mstat_mie_q  <= mstat_mie_d;
            mstat_mpie_q <= mstat_mpie_d;
            mie_mtie_q   <= mie_mtie_d;
            mie_meie_q   <= mie_meie_d;
            mtvec_q      <= mtvec_d;
            mscratch_q   <= mscratch_d;
            mepc_q       <= mepc_d;
            mcause_q     <= mcause_d;
            irq_sync1_q  <= irq_sync1_d;
            irq_sync2_q  <= irq_sync2_d;
        end
    end

    csr_timer u_timer (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .mcycle_we_i   (we_mcycle),
        .mcycleh_we_i  (we_mcycleh),
        .mtimecmp_we_i (we_mtimecmp),
        .wval_i        (wval),
        .mcycle_o      (mcycle),
        .mcycleh_o     (mcycleh),
        .mtimecmp_o    (mtimecmp),
        .mtip_o        (mtip)
    );

    assign bus.rdata_o    = rdata;
    assign bus.ipending_o = mstat_mie_q && ((mie_meie_q && meip) || (mie_mtie_q && mtip));
    assign bus.mtvec_o    = mtvec_q;
    assign bus.mepc_o     = mepc_q;

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed, table-driven bench for csr_unit.
// Inputs change just after the falling edge; outputs are sampled before
// the next rising edge.
`timescale 1ns/1ps
module tb_csr_unit;

    logic clk_i;
    logic rst_i;
    logic ext_irq_i;
    int   checks;
    int   errors;

    csr_if bus ();

    csr_unit dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ext_irq_i (ext_irq_i),
        .bus       (bus.slave)
    );

    initial clk_i = 1'b0;
    always #50 clk_i = ~clk_i;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        w;
        logic        s;
        logic        c;
        logic [31:0] exp_old;
        logic [31:0] exp_new;
    } vec_t;

    vec_t vecs [19];

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [11:0] addr, input logic [31:0] wdata,
                                  input logic w, input logic s, input logic c);
        bus.csr_addr_i  = addr;
        bus.wdata_i     = wdata;
        bus.csr_write_i = w;
        bus.csr_set_i   = s;
        bus.csr_clear_i = c;
    endtask

    task automatic idle_bus();
        apply_stimulus(12'h000, 32'h0, 1'b0, 1'b0, 1'b0);
        bus.csr_interrupt_i = 1'b0;
        bus.csr_mret_i      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic read_check(input string name, input logic [11:0] addr,
                              input logic [31:0] exp);
        apply_stimulus(addr, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        check_output(name, bus.rdata_o, exp);
    endtask

    task automatic read_value(input logic [11:0] addr, output logic [31:0] val);
        apply_stimulus(addr, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        val = bus.rdata_o;
    endtask

    initial begin
        logic [31:0] lo_before;
        logic [31:0] cyc;
        bit          found;

        checks    = 0;
        errors    = 0;
        ext_irq_i = 1'b0;
        bus.pc_i  = 32'h0;
        idle_bus();
        rst_i = 1'b1;

        // addr, wdata, w, s, c, old value in op cycle, value afterwards
        vecs[0]  = '{12'h305, 32'h0000_0103, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0100};
        vecs[1]  = '{12'h340, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[2]  = '{12'h340, 32'h0000_0010, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEFF};
        vecs[3]  = '{12'h340, 32'h0000_00FF, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEFF, 32'hDEAD_BE00};
        vecs[4]  = '{12'h340, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'hDEAD_BE00, 32'hDEAD_BE00};
        vecs[5]  = '{12'h340, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'hDEAD_BE00, 32'hDEAD_BE00};
        vecs[6]  = '{12'h340, 32'h0000_F00F, 1'b1, 1'b1, 1'b1, 32'hDEAD_BE00, 32'h0000_F00F};
        vecs[7]  = '{12'h340, 32'h0000_00F0, 1'b0, 1'b1, 1'b1, 32'h0000_F00F, 32'h0000_F0FF};
        vecs[8]  = '{12'h304, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0880};
        vecs[9]  = '{12'h304, 32'h0000_0080, 1'b0, 1'b0, 1'b1, 32'h0000_0880, 32'h0000_0800};
        vecs[10] = '{12'h300, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0000_1800, 32'h0000_1888};
        vecs[11] = '{12'h300, 32'h0000_0008, 1'b0, 1'b0, 1'b1, 32'h0000_1888, 32'h0000_1880};
        vecs[12] = '{12'h300, 32'h0000_0080, 1'b0, 1'b0, 1'b1, 32'h0000_1880, 32'h0000_1800};
        vecs[13] = '{12'h341, 32'h1234_5677, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h1234_5674};
        vecs[14] = '{12'h342, 32'h0000_0055, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0055};
        vecs[15] = '{12'h344, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
        vecs[16] = '{12'h123, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
        vecs[17] = '{12'h7C0, 32'h0000_1000, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_1000};
        vecs[18] = '{12'h305, 32'h0000_0003, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0100};

        // Reset state
        tick();
        tick();
        rst_i = 1'b0;
        read_check("rst_mstatus", 12'h300, 32'h0000_1800);
        read_check("rst_mtimecmp", 12'h7C0, 32'hFFFF_FFFF);
        read_check("rst_mcycle", 12'hB00, 32'h0000_0000);
        check_output("rst_ipending", {31'b0, bus.ipending_o}, 32'h0);
        check_output("rst_mtvec_o", bus.mtvec_o, 32'h0);
        check_output("rst_mepc_o", bus.mepc_o, 32'h0);

        // Single-cycle CSR operations from the table
        for (int i = 0; i < 19; i++) begin
            apply_stimulus(vecs[i].addr, vecs[i].wdata, vecs[i].w, vecs[i].s, vecs[i].c);
            #1;
            check_output($sformatf("vec%0d_old", i), bus.rdata_o, vecs[i].exp_old);
            tick();
            read_check($sformatf("vec%0d_new", i), vecs[i].addr, vecs[i].exp_new);
        end
        check_output("mtvec_o", bus.mtvec_o, 32'h0000_0100);
        check_output("mepc_o_sw", bus.mepc_o, 32'h1234_5674);

        // Counter: high-half write holds the low half, then 64-bit wrap
        read_value(12'hB00, lo_before);
        apply_stimulus(12'hB80, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        tick();
        read_check("mcycle_held", 12'hB00, lo_before);
        read_check("mcycleh_wr", 12'hB80, 32'hFFFF_FFFF);
        apply_stimulus(12'hB00, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        tick();
        read_check("mcycle_wr", 12'hB00, 32'hFFFF_FFFE);
        read_check("mcycleh_held", 12'hB80, 32'hFFFF_FFFF);
        tick();
        read_check("mcycle_inc", 12'hB00, 32'hFFFF_FFFF);
        tick();
        read_check("mcycle_wrap", 12'hB00, 32'h0000_0000);
        read_check("mcycleh_wrap", 12'hB80, 32'h0000_0000);

        // External interrupt: enable MIE, raise ext_irq, trap entry
        apply_stimulus(12'h300, 32'h0000_0008, 1'b0, 1'b1, 1'b0);
        tick();
        idle_bus();
        ext_irq_i = 1'b1;
        tick();
        check_output("ipend_lat1", {31'b0, bus.ipending_o}, 32'h0);
        tick();
        check_output("ipend_lat2", {31'b0, bus.ipending_o}, 32'h1);
        bus.csr_interrupt_i = 1'b1;
        bus.pc_i = 32'h0000_0047;
        tick();
        idle_bus();
        check_output("trap_ipend_off", {31'b0, bus.ipending_o}, 32'h0);
        check_output("trap_mepc", bus.mepc_o, 32'h0000_0044);
        read_check("trap_mcause", 12'h342, 32'h8000_000B);
        read_check("trap_mstatus", 12'h300, 32'h0000_1880);

        // mret together with an mstatus write: mret wins
        ext_irq_i = 1'b0;
        apply_stimulus(12'h300, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        bus.csr_mret_i = 1'b1;
        tick();
        idle_bus();
        read_check("mret_mstatus", 12'h300, 32'h0000_1888);
        check_output("mret_mepc", bus.mepc_o, 32'h0000_0044);

        // Timer interrupt: counter from 0, mtimecmp = 20
        apply_stimulus(12'hB00, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        apply_stimulus(12'h7C0, 32'd20, 1'b1, 1'b0, 1'b0);
        tick();
        apply_stimulus(12'h304, 32'h0000_0880, 1'b1, 1'b0, 1'b0);
        tick();
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            read_value(12'hB00, cyc);
            if (cyc == 32'd20) begin
                found = 1'b1;
                check_output("mtip_pre", {31'b0, bus.ipending_o}, 32'h0);
                tick();
                check_output("mtip_ipend", {31'b0, bus.ipending_o}, 32'h1);
                read_check("mtip_mip", 12'h344, 32'h0000_0080);
            end else begin
                tick();
            end
        end
        if (!found) begin
            errors++;
            $display("[TB] FAIL mtip_wait: mcycle never read 20 (last 0x%08h)", cyc);
        end

        // Both sources pending: external takes priority in mcause
        ext_irq_i = 1'b1;
        tick();
        tick();
        read_check("both_mip", 12'h344, 32'h0000_0880);
        bus.csr_interrupt_i = 1'b1;
        bus.pc_i = 32'h0000_0100;
        tick();
        idle_bus();
        read_check("both_mcause", 12'h342, 32'h8000_000B);
        check_output("both_mepc", bus.mepc_o, 32'h0000_0100);

        // Timer only: mcause is the timer code
        ext_irq_i = 1'b0;
        bus.csr_mret_i = 1'b1;
        tick();
        idle_bus();
        tick();
        tick();
        tick();
        read_check("tmr_mip", 12'h344, 32'h0000_0080);
        check_output("tmr_ipend", {31'b0, bus.ipending_o}, 32'h1);
        bus.csr_interrupt_i = 1'b1;
        bus.pc_i = 32'h0000_0200;
        tick();
        idle_bus();
        read_check("tmr_mcause", 12'h342, 32'h8000_0007);
        read_check("tmr_mstatus", 12'h300, 32'h0000_1880);

        // Trap entry with mscratch write and mret: trap wins over both
        apply_stimulus(12'h340, 32'h1111_1111, 1'b1, 1'b0, 1'b0);
        bus.csr_interrupt_i = 1'b1;
        bus.csr_mret_i = 1'b1;
        bus.pc_i = 32'h0000_0300;
        tick();
        idle_bus();
        read_check("trapwr_mscratch", 12'h340, 32'h0000_F0FF);
        read_check("trapmret_mstatus", 12'h300, 32'h0000_1800);
        check_output("trapmret_mepc", bus.mepc_o, 32'h0000_0300);

        // Reset while strobes are active
        apply_stimulus(12'h340, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
        bus.csr_interrupt_i = 1'b1;
        bus.csr_mret_i = 1'b1;
        ext_irq_i = 1'b1;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        idle_bus();
        read_check("mrst_mscratch", 12'h340, 32'h0000_0000);
        read_check("mrst_mstatus", 12'h300, 32'h0000_1800);
        read_check("mrst_mtimecmp", 12'h7C0, 32'hFFFF_FFFF);
        read_check("mrst_mie", 12'h304, 32'h0000_0000);
        read_check("mrst_mcause", 12'h342, 32'h0000_0000);
        read_check("mrst_mip", 12'h344, 32'h0000_0000);
        check_output("mrst_mtvec_o", bus.mtvec_o, 32'h0);
        check_output("mrst_mepc_o", bus.mepc_o, 32'h0);
        check_output("mrst_ipend", {31'b0, bus.ipending_o}, 32'h0);
        ext_irq_i = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
